// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
//   Turns PS/2 set-2 scan codes into ASCII characters. It tracks the break
//   (0xF0) and extended (0xE0) prefixes, the shift keys and the last key made,
//   so typematic repeats of a held key are suppressed. Characters are queued
//   in a FIFO and leave through a valid/ready handshake.
//
//   Optional feature: define LOWERCASE_EN to output letters in lowercase
//   unless a shift key is held. Without it, letters are always uppercase.
//
// Ports
//   clock        system clock, rising edge
//   resetn       asynchronous active-low reset
//   scan_code    byte from the PS/2 receiver
//   scan_valid   one-cycle strobe qualifying scan_code
//   ascii_data   FIFO head character (0x00 when the FIFO is empty)
//   ascii_valid  FIFO non-empty
//   ascii_ready  consumer takes the head this cycle
//   fifo_count   number of entries held
//   shift_held   either shift key is down
//   overflow     one-cycle pulse: a character was dropped on a full FIFO
//
// State | meaning
//   S_IDLE      | no prefix pending; make codes are translated
//   S_BREAK     | 0xF0 seen; the next code is a key release
//   S_EXT       | 0xE0 seen; the next code is an extended key
//   S_EXT_BREAK | 0xE0 0xF0 seen; the next code is ignored

module ps2_ascii_lut (
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);
  always_comb begin
    ascii_o = 8'h00;
    unique case (code_i)
      8'h1C: ascii_o = "A";  8'h32: ascii_o = "B";  8'h21: ascii_o = "C";
      8'h23: ascii_o = "D";  8'h24: ascii_o = "E";  8'h2B: ascii_o = "F";
      8'h34: ascii_o = "G";  8'h33: ascii_o = "H";  8'h43: ascii_o = "I";
      8'h3B: ascii_o = "J";  8'h42: ascii_o = "K";  8'h4B: ascii_o = "L";
      8'h3A: ascii_o = "M";  8'h31: ascii_o = "N";  8'h44: ascii_o = "O";
      8'h4D: ascii_o = "P";  8'h15: ascii_o = "Q";  8'h2D: ascii_o = "R";
      8'h1B: ascii_o = "S";  8'h2C: ascii_o = "T";  8'h3C: ascii_o = "U";
      8'h2A: ascii_o = "V";  8'h1D: ascii_o = "W";  8'h22: ascii_o = "X";
      8'h35: ascii_o = "Y";  8'h1A: ascii_o = "Z";
      8'h45: ascii_o = "0";  8'h16: ascii_o = "1";  8'h1E: ascii_o = "2";
      8'h26: ascii_o = "3";  8'h25: ascii_o = "4";  8'h2E: ascii_o = "5";
      8'h36: ascii_o = "6";  8'h3D: ascii_o = "7";  8'h3E: ascii_o = "8";
      8'h46: ascii_o = "9";
      8'h29: ascii_o = 8'h20;
      8'h5A: ascii_o = 8'h0A;
      8'h66: ascii_o = 8'h08;
      default: ascii_o = 8'h00;
    endcase
  end
endmodule

module ps2_key_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [7:0]       scan_code,
  input  logic             scan_valid,
  output logic [7:0]       ascii_data,
  output logic             ascii_valid,
  input  logic             ascii_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             shift_held,
  output logic             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

  state_t           state_q, state_d;
  logic             shift_q, shift_d;
  logic [7:0]       last_q, last_d;
  logic             push;
  logic [7:0]       push_data;
  logic [7:0]       lut_char;
  logic [7:0]       char_adj;
  logic             is_shift;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [CNT_W-1:0] wr_q, rd_q;
  logic             overflow_q;
  logic             pop, full, do_push, drop;

  ps2_ascii_lut u_lut (
    .code_i  (scan_code),
    .ascii_o (lut_char)
  );

  assign is_shift = (scan_code == 8'h12) || (scan_code == 8'h59);

  always_comb begin
    char_adj = lut_char;
`ifdef LOWERCASE_EN
    if (lut_char >= 8'h41 && lut_char <= 8'h5A && !shift_q)
      char_adj = lut_char + 8'h20;
`endif
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    last_d    = last_q;
    push      = 1'b0;
    push_data = 8'h00;
    if (scan_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (scan_code == 8'hF0)      state_d = S_BREAK;
          else if (scan_code == 8'hE0) state_d = S_EXT;
          else if (is_shift)           shift_d = 1'b1;
          // Held keys re-send their make code; only the first one counts.
          else if (lut_char != 8'h00 && scan_code != last_q) begin
            push      = 1'b1;
            push_data = char_adj;
            last_d    = scan_code;
          end
        end
        S_BREAK: begin
          state_d = S_IDLE;
          if (is_shift)            shift_d = 1'b0;
          if (scan_code == last_q) last_d  = 8'h00;
        end
        S_EXT: begin
          if (scan_code == 8'hF0) state_d = S_EXT_BREAK;
          else begin
            state_d = S_IDLE;
            if (scan_code == 8'h5A) begin
              push      = 1'b1;
              push_data = 8'h0A;
            end
          end
        end
        S_EXT_BREAK: state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      shift_q <= 1'b0;
      last_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      last_q  <= last_d;
    end
  end

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign fifo_count  = wr_q - rd_q;
  assign ascii_valid = (fifo_count != '0);
  assign full        = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop         = ascii_valid && ascii_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_push     = push && (!full || pop);
  assign drop        = push && full && !pop;
  assign ascii_data  = ascii_valid ? mem[rd_q[AW-1:0]] : 8'h00;
  assign shift_held  = shift_q;
  assign overflow    = overflow_q;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_q[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      overflow_q <= drop;
    end
  end
endmodule

// File: tb/tb_ps2_key_sequencer.sv
module tb_ps2_key_sequencer;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    scan_code = 8'h00;
  logic          scan_valid = 1'b0;
  logic          ascii_ready = 1'b0;
  logic [7:0]    ascii_data;
  logic          ascii_valid;
  logic [CW-1:0] fifo_count;
  logic          shift_held;
  logic          overflow;

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .ascii_data  (ascii_data),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .fifo_count  (fifo_count),
    .shift_held  (shift_held),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int ovf_seen = 0;

  // Reference model: key map plus prefix flags, shift, last key and a queue.
  bit [7:0] keymap [bit [7:0]];
  bit       m_brk = 0, m_ext = 0, m_shift = 0, exp_ovf = 0;
  bit [7:0] m_last = 8'h00;
  int       m_count = 0;
  bit [7:0] exp_q [$];

  bit [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  bit [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  bit [7:0] pool [16] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h45, 8'hF0, 8'hF0, 8'hE0,
    8'h12, 8'h59, 8'h5A, 8'h66, 8'h29, 8'h05, 8'h75, 8'h1A};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [7:0] translate(input bit [7:0] c, input bit shifted);
    bit [7:0] ch;
    if (!keymap.exists(c)) return 8'h00;
    ch = keymap[c];
`ifdef LOWERCASE_EN
    if (ch >= "A" && ch <= "Z" && !shifted) ch = ch + 8'd32;
`else
    if (shifted) ch = ch;
`endif
    return ch;
  endfunction

  always @(negedge resetn) begin
    m_brk = 0; m_ext = 0; m_shift = 0; m_last = 8'h00;
    m_count = 0; exp_ovf = 0; exp_q.delete();
  end

  always @(posedge clock) begin
    bit       pop_now, want;
    bit [7:0] ch;
    int       pre;
    if (resetn) begin
      want = 0;
      ch = 8'h00;
      pre = m_count;
      pop_now = ascii_ready && (pre > 0);
      if (scan_valid) begin
        if (m_brk) begin
          if (!m_ext) begin
            if (scan_code == 8'h12 || scan_code == 8'h59) m_shift = 0;
            if (scan_code == m_last) m_last = 8'h00;
          end
          m_brk = 0; m_ext = 0;
        end else if (m_ext) begin
          if (scan_code == 8'hF0) m_brk = 1;
          else begin
            m_ext = 0;
            if (scan_code == 8'h5A) begin want = 1; ch = 8'h0A; end
          end
        end else if (scan_code == 8'hF0) m_brk = 1;
        else if (scan_code == 8'hE0) m_ext = 1;
        else if (scan_code == 8'h12 || scan_code == 8'h59) m_shift = 1;
        else begin
          ch = translate(scan_code, m_shift);
          if (ch != 8'h00 && scan_code != m_last) begin
            want = 1;
            m_last = scan_code;
          end
        end
      end
      exp_ovf = 0;
      m_count = pre - (pop_now ? 1 : 0);
      if (want) begin
        if (pre < DEPTH || pop_now) begin
          exp_q.push_back(ch);
          m_count++;
        end else exp_ovf = 1;
      end
    end
  end

  // Pop monitor: a handshake at this edge consumes the current head.
  always @(posedge clock) begin
    if (resetn && ascii_valid && ascii_ready) begin
      pops++;
      check("pop_has_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("ascii_data", ascii_data, exp_q.pop_front());
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      check("fifo_count", fifo_count, m_count);
      check("ascii_valid", ascii_valid, int'(m_count > 0));
      check("overflow", overflow, exp_ovf);
      check("shift_held", shift_held, m_shift);
      if (!ascii_valid) check("empty_data", ascii_data, 0);
      if (overflow) ovf_seen++;
    end
  end

  task automatic do_reset();
    @(negedge clock);
    #2;
    resetn = 1'b0;
    scan_valid = 1'b0;
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_valid", ascii_valid, 0);
    check("rst_data", ascii_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_shift", shift_held, 0);
    @(negedge clock);
    #2;
    resetn = 1'b1;
  endtask

  task automatic key(input bit [7:0] c);
    @(negedge clock);
    scan_code = c;
    scan_valid = 1'b1;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) begin
      @(negedge clock);
      scan_valid = 1'b0;
      ascii_ready = rdy;
    end
  endtask

  initial begin
    for (int i = 0; i < 26; i++) keymap[letter_codes[i]] = 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) keymap[digit_codes[i]] = 8'h30 + 8'(i);
    keymap[8'h29] = 8'h20;
    keymap[8'h5A] = 8'h0A;
    keymap[8'h66] = 8'h08;

    // Single key press and release
    ascii_ready = 1'b1;
    do_reset();
    pops = 0;
    key(8'h1C); key(8'hF0); key(8'h1C);
    idle(5, 1);
    check("t1_chars", pops, 1);

    // Typematic repeat suppression
    do_reset();
    pops = 0;
    key(8'h1C); key(8'h1C); key(8'h1C); key(8'hF0); key(8'h1C); key(8'h1C);
    idle(5, 1);
    check("t2_chars", pops, 2);

    // Shift handling
    do_reset();
    pops = 0;
    key(8'h12);
    key(8'h32);
    idle(1, 1);
    check("t3_shift_down", shift_held, 1);
    key(8'hF0); key(8'h32); key(8'hF0); key(8'h12); key(8'h32);
    idle(5, 1);
    check("t3_chars", pops, 2);
    check("t3_shift_up", shift_held, 0);

    // Extended codes
    do_reset();
    pops = 0;
    key(8'hE0); key(8'h5A);
    key(8'hE0); key(8'h75);
    key(8'hE0); key(8'hF0); key(8'h75);
    key(8'hF0); key(8'h77);
    idle(5, 1);
    check("t4_chars", pops, 1);
    key(8'h21);
    idle(4, 1);
    check("t4_back_idle", pops, 2);

    // Overflow with consumer stalled, then drain
    ascii_ready = 1'b0;
    do_reset();
    pops = 0;
    ovf_seen = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      key(letter_codes[i]); key(8'hF0); key(letter_codes[i]);
    end
    idle(3, 0);
    check("t5_full_count", fifo_count, DEPTH);
    check("t5_ovf_pulses", ovf_seen, 1);
    idle(DEPTH + 4, 1);
    check("t5_drained", pops, DEPTH);

    // Push and pop together on a full FIFO
    ascii_ready = 1'b0;
    do_reset();
    ovf_seen = 0;
    for (int i = 0; i < DEPTH; i++) begin
      key(letter_codes[i]); key(8'hF0); key(letter_codes[i]);
    end
    idle(2, 0);
    @(negedge clock);
    ascii_ready = 1'b1;
    scan_code = 8'h4B;
    scan_valid = 1'b1;
    @(negedge clock);
    ascii_ready = 1'b0;
    scan_valid = 1'b0;
    #1;
    check("t6_count", fifo_count, DEPTH);
    check("t6_no_ovf", overflow, 0);
    idle(DEPTH + 4, 1);
    check("t6_ovf_pulses", ovf_seen, 0);

    // Reset mid-stream with a pending break prefix
    ascii_ready = 1'b0;
    do_reset();
    key(8'h1C); key(8'h32); key(8'hF0);
    idle(1, 0);
    do_reset();
    pops = 0;
    key(8'h32);
    idle(4, 1);
    check("t7_after_reset", pops, 1);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      ascii_ready = ($urandom_range(0, 3) != 0);
      scan_valid = ($urandom_range(0, 9) < 6);
      scan_code = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
    end
    idle(DEPTH + 6, 1);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
